gabor_window_gen: RTL and testbench
===================================

GABOR_WINDOW_GEN -- requirements
Module: gabor_window_gen

Interface
REQ-001 Parameter IMAGE_WIDTH, default 512, pixels per image row.
REQ-002 Parameter IMAGE_HEIGHT, default 512, rows per frame.
REQ-003 Parameter KERNEL_LENGTH, default 5, window edge; only the value 5 is supported.
REQ-004 Parameter PIX_W, default 8, input pixel width.
REQ-005 Parameter IMAGE_SIZE, default 9, output element width (sign-magnitude).
REQ-006 Ports: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  single-cycle pulse that arms one frame; ignored unless state is IDLE.
REQ-010 s_valid  in  1  input pixel valid.
REQ-011 s_ready  out  1  input pixel accepted when s_valid and s_ready are both high.
REQ-012 s_pixel  in  PIX_W  raster-order unsigned pixel.
REQ-013 m_valid  out  1  window valid.
REQ-014 m_ready  in  1  downstream convolution stage accepts the window.
REQ-015 m_window  out  25*IMAGE_SIZE  flattened window; element r*5+c occupies bits [(r*5+c)*IMAGE_SIZE +: IMAGE_SIZE]; r=0 is the top (oldest) row and c=0 is the leftmost column.
REQ-016 m_row, m_col  out  9 each  image coordinates of the window's top-left pixel.
REQ-017 busy  out  1  high in RUN and DRAIN.
REQ-018 frame_done  out  1  one-cycle pulse when the frame completes.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN. IDLE->RUN on start. RUN->DRAIN on the handshake that accepts pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1). DRAIN->IDLE on the m handshake of the final window.
REQ-020 s_ready = (state==RUN) && (!m_valid || m_ready); s_ready is low in IDLE and DRAIN.
REQ-021 Column counter and row counter advance on each accepted pixel. The column wraps from IMAGE_WIDTH-1 to 0 and increments the row at the same time.
REQ-022 Line buffers: 4 lines of IMAGE_WIDTH x PIX_W, indexed by column.
  - On accept: read all four lines at the current column, then write lb0<=pixel, lb1<=old lb0, lb2<=old lb1, lb3<=old lb2 at that column.
REQ-023 Window register: 5x5 array. On accept, every column shifts left by one, and the new rightmost column is {lb3, lb2, lb1, lb0, pixel}, top to bottom.
REQ-024 Each output element is {1'b0, pixel}, zero-extended to IMAGE_SIZE bits.
REQ-025 m_valid is set on the clock edge that accepts a pixel at row>=4 and col>=4.
  - m_row = row-4, m_col = col-4.
  - Latency is 1 cycle from the accept to m_valid.
REQ-026 m_valid is cleared on an m handshake unless a new window is produced on the same edge.
REQ-027 While m_valid && !m_ready, m_window, m_row and m_col hold stable and no pixel is accepted.
REQ-028 Pixels at col<4 or row<4 update the line buffers and window but produce no window.
  - Exactly (IMAGE_WIDTH-4)*(IMAGE_HEIGHT-4) windows per frame.
  - No window straddles a row boundary.
REQ-029 frame_done pulses in the cycle after the final window handshake; busy falls on the same edge.
REQ-030 start while busy has no effect. s_valid while IDLE or DRAIN is not accepted.

Reset
REQ-031 Asserting rst_n low, at any time including mid-frame:
  - state=IDLE, counters=0.
  - m_valid=0, s_ready=0, busy=0, frame_done=0.
  - m_row=0, m_col=0, m_window=0.
REQ-032 Line-buffer contents are not reset; the warm-up rows guarantee that stale data never reaches a valid window.

Structure
REQ-033 A shared package holds:
  - IMAGE_WIDTH, IMAGE_HEIGHT, KERNEL_LENGTH and IMAGE_SIZE defaults;
  - the window-element type (IMAGE_SIZE-bit sign-magnitude);
  - the FSM state enum.
REQ-034 One sub-module, gabor_line_buffer: a single IMAGE_WIDTH x PIX_W column-addressed memory with read-before-write. It is instantiated four times.

Verification (bench parameters IMAGE_WIDTH=8, IMAGE_HEIGHT=6, pixel = row*16+col)
REQ-035 Full frame, m_ready always 1 -> 8 windows emitted.
  - First window: m_row=0, m_col=0, element 0 = 0x000, element 24 = 0x044.
  - Last window: m_row=1, m_col=3, element 0 = 0x013, element 24 = 0x057.
  - frame_done pulses once.
REQ-036 Output backpressure: m_ready=0 for 10 cycles while the first window is valid -> s_ready=0, window held bit-stable, no pixel lost; subsequent windows identical to the REQ-035 sequence.
REQ-037 Input gaps: s_valid toggled with a random 50% duty -> window contents and order identical to REQ-035; latency is 1 cycle after each window-producing accept.
REQ-038 rst_n low after 20 accepted pixels, then a new start and a full frame -> m_valid=0 during reset; the second frame's output equals REQ-035.
REQ-039 start pulsed while RUN, and s_valid held high in IDLE -> no state change; no pixel accepted before start.
REQ-040 Two back-to-back frames (start in the cycle after frame_done) -> 16 windows; the second frame contains no data from the first.

Source files
------------

// File: rtl/gabor_window_gen_pkg.sv
// Shared definitions for the Gabor 5x5 window generator: size defaults,
// window element type and control FSM encoding.
package gabor_window_gen_pkg;

  localparam int IMAGE_WIDTH_DEF   = 512;
  localparam int IMAGE_HEIGHT_DEF  = 512;
  localparam int KERNEL_LENGTH_DEF = 5;
  localparam int PIX_W_DEF         = 8;
  localparam int IMAGE_SIZE_DEF    = 9;
  localparam int COORD_W           = 9;

  // Sign-magnitude window element; pixels are unsigned so the sign bit is 0.
  typedef logic [IMAGE_SIZE_DEF-1:0] win_elem_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } gw_state_e;

endpackage

// File: rtl/gabor_line_buffer.sv
// One image line of pixels, column addressed. The read port is asynchronous so
// a same-cycle write at the same column still returns the previous row's value.
module gabor_line_buffer #(
  parameter int IMAGE_WIDTH = 512,
  parameter int PIX_W       = 8,
  parameter int ADDR_W      = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic [PIX_W-1:0]  rd_data
);

  logic [PIX_W-1:0] mem_r [IMAGE_WIDTH];

  assign rd_data = mem_r[addr];

  // Column write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/gabor_window_gen.sv
// Raster pixel stream to 5x5 sliding window generator with valid/ready on both
// sides, one-cycle window latency and frame-level start/busy/done control.
module gabor_window_gen
  import gabor_window_gen_pkg::*;
#(
  parameter int IMAGE_WIDTH   = IMAGE_WIDTH_DEF,
  parameter int IMAGE_HEIGHT  = IMAGE_HEIGHT_DEF,
  parameter int KERNEL_LENGTH = KERNEL_LENGTH_DEF,
  parameter int PIX_W         = PIX_W_DEF,
  parameter int IMAGE_SIZE    = IMAGE_SIZE_DEF
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  input  logic [PIX_W-1:0]                              s_pixel,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic [KERNEL_LENGTH*KERNEL_LENGTH*IMAGE_SIZE-1:0] m_window,
  output logic [COORD_W-1:0]                            m_row,
  output logic [COORD_W-1:0]                            m_col,
  output logic                                          busy,
  output logic                                          frame_done
);

  localparam int K     = KERNEL_LENGTH;
  localparam int NLB   = K - 1;
  localparam int LB_AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMAGE_WIDTH - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMAGE_HEIGHT - 1);
  localparam logic [COORD_W-1:0] EDGE     = COORD_W'(K - 1);

  gw_state_e              state_r, state_next_s;
  logic [COORD_W-1:0]     col_r, row_r, m_row_r, m_col_r;
  logic                   m_valid_r, busy_r, frame_done_r;
  logic                   accept_s, m_hs_s, last_pix_s, win_hit_s;
  logic [PIX_W-1:0]       lb_rd_s [NLB];
  logic [PIX_W-1:0]       lb_wr_s [NLB];
  logic [IMAGE_SIZE-1:0]  new_col_s [K];
  logic [IMAGE_SIZE-1:0]  win_r [K][K];

  assign s_ready    = (state_r == ST_RUN) && (!m_valid_r || m_ready);
  assign accept_s   = s_valid && s_ready;
  assign m_hs_s     = m_valid_r && m_ready;
  assign last_pix_s = accept_s && (col_r == COL_LAST) && (row_r == ROW_LAST);
  assign win_hit_s  = accept_s && (col_r >= EDGE) && (row_r >= EDGE);

  assign m_valid    = m_valid_r;
  assign m_row      = m_row_r;
  assign m_col      = m_col_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  // Line buffers form a vertical shift chain: lb0 holds the previous row.
  for (genvar i = 0; i < NLB; i++) begin : g_lb
    gabor_line_buffer #(
      .IMAGE_WIDTH(IMAGE_WIDTH),
      .PIX_W      (PIX_W),
      .ADDR_W     (LB_AW)
    ) u_lb (
      .clk    (clk),
      .wr_en  (accept_s),
      .addr   (col_r[LB_AW-1:0]),
      .wr_data(lb_wr_s[i]),
      .rd_data(lb_rd_s[i])
    );
  end

  // Line-buffer write data and new rightmost window column (oldest row on top).
  always_comb begin
    lb_wr_s[0] = s_pixel;
    for (int i = 1; i < NLB; i++) begin
      lb_wr_s[i] = lb_rd_s[i-1];
    end
    for (int r = 0; r < NLB; r++) begin
      new_col_s[r] = IMAGE_SIZE'(lb_rd_s[NLB-1-r]);
    end
    new_col_s[K-1] = IMAGE_SIZE'(s_pixel);
  end

  // Flatten the window register onto the output bus.
  always_comb begin
    m_window = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        m_window[(r*K+c)*IMAGE_SIZE +: IMAGE_SIZE] = win_r[r][c];
      end
    end
  end

  // Frame control next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  if (start)      state_next_s = ST_RUN;   else state_next_s = ST_IDLE;
      ST_RUN:   if (last_pix_s) state_next_s = ST_DRAIN; else state_next_s = ST_RUN;
      ST_DRAIN: if (m_hs_s)     state_next_s = ST_IDLE;  else state_next_s = ST_DRAIN;
      default:                  state_next_s = ST_IDLE;
    endcase
  end

  // State register with busy and the end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      busy_r       <= (state_next_s != ST_IDLE);
      frame_done_r <= (state_r == ST_DRAIN) && m_hs_s;
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= {COORD_W{1'b0}};
      row_r <= {COORD_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      col_r <= {COORD_W{1'b0}};
      row_r <= {COORD_W{1'b0}};
    end else if (accept_s) begin
      if (col_r == COL_LAST) begin
        col_r <= {COORD_W{1'b0}};
        row_r <= (row_r == ROW_LAST) ? {COORD_W{1'b0}} : row_r + COORD_W'(1);
      end else begin
        col_r <= col_r + COORD_W'(1);
      end
    end
  end

  // 5x5 window shifts left by one column per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_r[r][c] <= {IMAGE_SIZE{1'b0}};
        end
      end
    end else if (accept_s) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_r[r][c] <= win_r[r][c+1];
        end
        win_r[r][K-1] <= new_col_s[r];
      end
    end
  end

  // Output valid and top-left coordinates; a new window overrides the consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      m_row_r   <= {COORD_W{1'b0}};
      m_col_r   <= {COORD_W{1'b0}};
    end else if (win_hit_s) begin
      m_valid_r <= 1'b1;
      m_row_r   <= row_r - EDGE;
      m_col_r   <= col_r - EDGE;
    end else if (m_hs_s) begin
      m_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gabor_window_gen.sv
// Directed bench for gabor_window_gen on an 8x6 image with pixel = row*16+col+offset.
module tb_gabor_window_gen;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 4) * (H - 4);
  localparam int EW   = 9;
  localparam int WW   = 25 * EW;

  logic          clk, rst_n, start, s_valid, s_ready, m_valid, m_ready, busy, frame_done;
  logic [7:0]    s_pixel;
  logic [WW-1:0] m_window;
  logic [8:0]    m_row, m_col;

  int total = 0;
  int bad   = 0;

  gabor_window_gen #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .KERNEL_LENGTH(5),
    .PIX_W        (8),
    .IMAGE_SIZE   (EW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_pixel   (s_pixel),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_window  (m_window),
    .m_row     (m_row),
    .m_col     (m_col),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(int p, int off);
    return 8'((p / W) * 16 + (p % W) + off);
  endfunction

  // Window w has top-left (w/4, w%4); element e sits at row e/5, column e%5.
  function automatic logic [WW-1:0] exp_window(int w, int off);
    logic [WW-1:0] v;
    logic [7:0]    px;
    v = '0;
    for (int e = 0; e < 25; e++) begin
      px = 8'(((w / 4) + e / 5) * 16 + (w % 4) + e % 5 + off);
      v[e*EW +: EW] = {1'b0, px};
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    #1;
    chki("done_once", 32'(frame_done), 0);
    @(negedge clk);
    start = 1'b0;
    chki("start_busy", 32'(busy), 1);
  endtask

  task automatic run_frame(input int gaps, input int bp, input int off, input int restart_at);
    int p, w, cyc, bpl, er, ec, fd;
    bit exp_win, restarted;
    p = 0; w = 0; cyc = 0; bpl = bp; er = 0; ec = 0; fd = 0;
    exp_win = 1'b0; restarted = 1'b0;
    while (w < NWIN && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (exp_win) begin
        chki("lat_valid", 32'(m_valid), 1);
        chki("lat_row", 32'(m_row), er);
        chki("lat_col", 32'(m_col), ec);
        exp_win = 1'b0;
      end
      if (restart_at >= 0 && !restarted && p == restart_at) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (m_valid && bpl > 0) begin
        m_ready = 1'b0;
        bpl--;
      end else begin
        m_ready = 1'b1;
      end
      s_valid = (p < NPIX) && (gaps == 0 || $urandom_range(0, 1) == 1);
      s_pixel = pix(p, off);
      #1;
      if (!m_ready) begin
        chki("bp_sready", 32'(s_ready), 0);
        chk("bp_hold", m_window, exp_window(0, off));
      end
      if (m_valid && m_ready) begin
        chki("win_row", 32'(m_row), w / 4);
        chki("win_col", 32'(m_col), w % 4);
        chk("win_data", m_window, exp_window(w, off));
        w++;
      end
      if (s_valid && s_ready) begin
        if (p / W >= 4 && p % W >= 4) begin
          exp_win = 1'b1;
          er = p / W - 4;
          ec = p % W - 4;
        end
        p++;
      end
    end
    chki("frame_pix", p, NPIX);
    chki("frame_win", w, NWIN);
    s_valid = 1'b0;
    m_ready = 1'b1;
    start   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (frame_done) begin
        fd++;
        chki("done_busy", 32'(busy), 0);
        chki("done_mvalid", 32'(m_valid), 0);
        break;
      end
    end
    chki("frame_done_seen", fd, 1);
  endtask

  initial begin
    int p, cyc;
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_pixel = 8'h00; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chki("rst_mvalid", 32'(m_valid), 0);
    chki("rst_sready", 32'(s_ready), 0);
    chki("rst_busy", 32'(busy), 0);
    chki("rst_done", 32'(frame_done), 0);
    chki("rst_mrow", 32'(m_row), 0);
    chki("rst_mcol", 32'(m_col), 0);
    chk("rst_window", m_window, '0);
    rst_n = 1'b1;

    // s_valid held in IDLE must not be accepted.
    s_valid = 1'b1;
    s_pixel = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chki("idle_sready", 32'(s_ready), 0);
      chki("idle_busy", 32'(busy), 0);
    end
    s_valid = 1'b0;

    do_start();
    run_frame(0, 0, 0, -1);
    do_start();
    run_frame(0, 10, 0, -1);
    do_start();
    run_frame(1, 0, 0, 20);

    // Mid-frame reset after 20 accepted pixels.
    do_start();
    p = 0;
    cyc = 0;
    while (p < 20 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      s_valid = 1'b1;
      s_pixel = pix(p, 8'h80);
      #1;
      if (s_ready) p++;
    end
    chki("pre_rst_pix", p, 20);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chki("mid_rst_mvalid", 32'(m_valid), 0);
    chki("mid_rst_sready", 32'(s_ready), 0);
    chki("mid_rst_busy", 32'(busy), 0);
    chki("mid_rst_mrow", 32'(m_row), 0);
    chk("mid_rst_window", m_window, '0);
    @(negedge clk);
    chki("mid_rst_hold", 32'(m_valid), 0);
    rst_n = 1'b1;
    do_start();
    run_frame(0, 0, 0, -1);

    // Back-to-back frames with distinct data.
    do_start();
    run_frame(0, 0, 8'h80, -1);
    do_start();
    run_frame(0, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
